btn_pulse_gen: RTL and testbench
================================

# btn_pulse_gen

Converts a raw, bouncing push-button input into clean single-cycle `signal` pulses for the lab counter blocks. It produces one pulse per debounced press. While the button stays held, it auto-repeats after a programmable delay. It sits between the board button pins and any counter that advances on a one-cycle `signal` strobe.

## Interface
- `DEBOUNCE_CYCLES`, 4: cycles the synchronized level must hold stable to accept a press or a release (≥1).
- `REPEAT_DELAY`, 10: cycles from the first pulse to the second pulse while held (≥1).
- `REPEAT_PERIOD`, 5: cycles between later repeat pulses while held (≥1).
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.
- `CNT_W`, 16: width of the internal timing counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) − 1.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst`=0 at a rising edge resets).
- `btn` in 1: raw, asynchronous button level; 1 = pressed.
- `enable` in 1: 0 masks `signal` output only; the FSM keeps running.
- `signal` out 1: registered pulse, high for exactly one cycle per accepted event.
- `held` out 1: registered, high while in HOLD_DELAY, REPEAT or DB_RELEASE.
- `state` out 3: current FSM state, for debug.

## Operation
- **Synchronizer:** `btn` passes through 2 flops, s1 then s2. `btn_s` = s2. The FSM reads only `btn_s`.
- **Counter:** a single `cnt` (CNT_W bits) is cleared on every state change. It never wraps in normal use.
- **State encoding:** IDLE=0, DB_PRESS=1, HOLD_DELAY=2, REPEAT=3, DB_RELEASE=4.
- **IDLE:** `btn_s`=1 → DB_PRESS.
- **DB_PRESS:**
  - `btn_s`=0 → IDLE, no pulse.
  - Else, if `cnt`==DEBOUNCE_CYCLES−1 → HOLD_DELAY and issue a pulse.
  - Else `cnt`++.
- **HOLD_DELAY:**
  - `btn_s`=0 → DB_RELEASE. This check has priority.
  - Else, if REPEAT_EN=1 and `cnt`==REPEAT_DELAY−1 → REPEAT and issue a pulse.
  - Else `cnt`++. With REPEAT_EN=0, `cnt` saturates and the state stays put.
- **REPEAT:**
  - `btn_s`=0 → DB_RELEASE. This check has priority.
  - Else, if `cnt`==REPEAT_PERIOD−1 → issue a pulse and clear `cnt`.
  - Else `cnt`++.
- **DB_RELEASE:**
  - `btn_s`=1 → HOLD_DELAY, `cnt` cleared, no pulse. A bounce on release never creates a new press.
  - Else, if `cnt`==DEBOUNCE_CYCLES−1 → IDLE.
  - Else `cnt`++.
- **Pulse output:** `signal` is registered as (pulse_event AND `enable`). When `enable` is 0, events are dropped, not queued.
- **Undefined state codes (5–7):** go to IDLE on the next edge.

## Timing
- **Reset values:** s1=0, s2=0, state=IDLE, `cnt`=0, `signal`=0, `held`=0. These take effect at the edge where `rst`=0.
- **Reset mid-operation:** reset overrides every transition. A pending pulse is lost. `signal` is 0 in the cycle after the reset edge.
- **Press latency:** take edge E0 as the edge that first samples `btn`=1 into s1.
  - E1: s2=1.
  - E2: state becomes DB_PRESS.
  - E2+DEBOUNCE_CYCLES: state becomes HOLD_DELAY and `signal`=1.
  - Total: `signal` goes high after edge E0+DEBOUNCE_CYCLES+2 and stays high for exactly one cycle.
- **Repeat spacing (held):** second pulse is exactly REPEAT_DELAY cycles after the first. Later pulses are every REPEAT_PERIOD cycles.
- **Release:** from `btn` falling, `held` drops DEBOUNCE_CYCLES+3 edges later (2 sync + 1 entry + count). No pulse is issued on release.
- **Simultaneous events:** release detection in REPEAT on the same edge as `cnt`==REPEAT_PERIOD−1 → go to DB_RELEASE, no pulse.
- **Pulse separation:** `signal` is never high for 2 consecutive cycles. Minimum spacing is min(REPEAT_DELAY, REPEAT_PERIOD) cycles.

## Test plan
- **Reset:** with `rst`=0 for 3 edges and `btn`=1 → `signal`=0, `held`=0, `state`=0 throughout. After release of reset, first `signal` appears after edge 6 (DEBOUNCE_CYCLES=4).
- **Clean press:** DEBOUNCE_CYCLES=4, REPEAT_EN=0, `btn` high for 20 cycles then low → exactly one `signal` pulse, high after edge E0+6. `held` is 1 until 7 edges after `btn` falls, then `state` returns to 0.
- **Bounce:** `btn` toggles 1,0,1,0 at 1-cycle spacing, then is stable 1 → no pulse during the bounce. One pulse follows 6 edges after the stable-1 sample.
- **Auto-repeat:** REPEAT_DELAY=10, REPEAT_PERIOD=5, `btn` held 40 cycles → pulses at t, t+10, t+15, t+20, t+25, … until release. No pulse after DB_RELEASE is entered.
- **Enable mask:** `enable`=0 during the first pulse and 1 during the repeats → first pulse suppressed, repeat pulses unchanged. There is no catch-up pulse.
- **Release bounce and mid-operation reset:**
  - In DB_RELEASE, `btn` returns to 1 → `state`=2, no pulse, next pulse 10 cycles later.
  - Assert `rst`=0 during REPEAT → next cycle `signal`=0, `held`=0, `state`=0.

Source files
------------

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: two-flop synchronizer, press/release debounce and
// optional auto-repeat, producing one-cycle pulses on signal.
//
// state      | meaning
// IDLE       | button released, waiting for a synchronized press
// DB_PRESS   | press seen, counting stable-high cycles
// HOLD_DELAY | press accepted, waiting out the initial repeat delay
// REPEAT     | auto-repeating every REPEAT_PERIOD cycles
// DB_RELEASE | release seen, counting stable-low cycles
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       enable,
    output logic       signal,
    output logic       held,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] DB_PRESS   = 3'd1;
    localparam logic [2:0] HOLD_DELAY = 3'd2;
    localparam logic [2:0] REPEAT     = 3'd3;
    localparam logic [2:0] DB_RELEASE = 3'd4;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic             s1, s2, btn_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             pulse;
    logic             held_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign btn_s = s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            signal  <= 1'b0;
            held    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            signal  <= pulse & enable;
            held    <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt + CNT_W'(1);
        pulse   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) state_d = DB_PRESS;
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_d = HOLD_DELAY;
                    pulse   = 1'b1;
                end
            end
            HOLD_DELAY: begin
                if (!btn_s) begin
                    state_d = DB_RELEASE;
                end else if (REPEAT_EN != 0 && cnt == DELAY_LAST) begin
                    state_d = REPEAT;
                    pulse   = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    cnt_d = cnt;
                end
            end
            REPEAT: begin
                // release wins over a coincident repeat pulse
                if (!btn_s) begin
                    state_d = DB_RELEASE;
                end else if (cnt == PERIOD_LAST) begin
                    pulse = 1'b1;
                    cnt_d = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_d = HOLD_DELAY;
                end else if (cnt == DB_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        held_d = (state_d == HOLD_DELAY) || (state_d == REPEAT) || (state_d == DB_RELEASE);
    end

    assign state = state_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed timing checks plus random button traffic,
// all compared each cycle against a timer/run-length model of the button.
module tb_btn_pulse_gen;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       btn    = 1'b0;
    logic       enable = 1'b1;
    logic       signal;
    logic       held;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1),
        .CNT_W          (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .enable(enable),
        .signal(signal),
        .held  (held),
        .state (state)
    );

    always #5 clk = ~clk;

    // Model: the FSM sees btn delayed by two edges; a press is accepted after
    // DEB+1 consecutive high samples, a release after DEB+1 consecutive low
    // samples; while held, pulses fall on absolute due times.
    bit ms1, ms2, mb, mpulse;
    bit mheld, mrel, mrep, mvalid, exp_sig;
    int run, zrun, due;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            ms1 = 0; ms2 = 0; run = 0; zrun = 0; due = 0;
            mheld = 0; mrel = 0; mrep = 0; exp_sig = 0;
            mvalid = 1;
        end else begin
            mb  = ms2;
            ms2 = ms1;
            ms1 = btn;
            mpulse = 0;
            if (!mheld) begin
                if (mb) begin
                    run++;
                    if (run == DEB + 1) begin
                        mpulse = 1; mheld = 1; mrel = 0; mrep = 0;
                        due = cyc + RD; run = 0;
                    end
                end else begin
                    run = 0;
                end
            end else if (!mrel) begin
                if (!mb) begin
                    mrel = 1; zrun = 1;
                end else if (cyc == due) begin
                    mpulse = 1; mrep = 1; due = cyc + RP;
                end
            end else begin
                if (mb) begin
                    mrel = 0; mrep = 0; due = cyc + RD;
                end else begin
                    zrun++;
                    if (zrun == DEB + 1) begin
                        mheld = 0; mrel = 0; run = 0;
                    end
                end
            end
            exp_sig = mpulse && enable;
        end
    end

    function automatic logic [31:0] exp_state();
        if (!mheld) return (run > 0) ? 32'd1 : 32'd0;
        if (mrel)   return 32'd4;
        if (mrep)   return 32'd3;
        return 32'd2;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            check("signal", 32'(signal), 32'(exp_sig));
            check("held",   32'(held),   32'(mheld));
            check("state",  32'(state),  exp_state());
        end
    end

    // kind: 0 = signal, 1 = held, 2 = state; at = cycle first seen, -1 on timeout
    task automatic wait_cond(input int kind, input int val, input int maxc, output int at);
        logic [31:0] v;
        at = -1;
        for (int k = 0; k < maxc && at < 0; k++) begin
            @(negedge clk);
            v = (kind == 0) ? 32'(signal) : (kind == 1) ? 32'(held) : 32'(state);
            if (v === 32'(val)) at = cyc;
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL wait kind=%0d: value %0d not seen, got %0d", kind, val, v);
        end
    endtask

    int at, at2, at3, e0, t2, nb;

    initial begin
        rst = 0; btn = 1; enable = 1;
        repeat (3) begin
            @(negedge clk);
            check("rst_signal", 32'(signal), 0);
            check("rst_held",   32'(held),   0);
            check("rst_state",  32'(state),  0);
        end

        // press latency and repeat spacing, button held through reset
        rst = 1;
        e0 = cyc + 1;
        wait_cond(0, 1, 40, at);
        check("press_latency", 32'(at - e0), 6);
        wait_cond(0, 1, 40, at2);
        check("repeat_delay", 32'(at2 - at), 10);
        wait_cond(0, 1, 40, at3);
        check("repeat_period", 32'(at3 - at2), 5);

        // release bounce back into HOLD_DELAY
        btn = 0;
        wait_cond(2, 4, 20, at);
        btn = 1;
        wait_cond(2, 2, 20, t2);
        wait_cond(0, 1, 40, at);
        check("rebounce_next_pulse", 32'(at - t2), 10);

        // reset during REPEAT
        wait_cond(2, 3, 40, at);
        rst = 0;
        @(negedge clk);
        check("midrst_signal", 32'(signal), 0);
        check("midrst_held",   32'(held),   0);
        check("midrst_state",  32'(state),  0);
        rst = 1; btn = 0;
        repeat (10) @(negedge clk);

        // enable mask on first pulse, repeats unaffected
        enable = 0; btn = 1;
        e0 = cyc + 1;
        repeat (7) @(negedge clk);
        check("mask_first", 32'(signal), 0);
        check("mask_state", 32'(state), 2);
        enable = 1;
        wait_cond(0, 1, 40, at);
        check("mask_repeat", 32'(at - (e0 + 6)), 10);

        // release latency
        repeat (3) @(negedge clk);
        btn = 0;
        e0 = cyc + 1;
        wait_cond(1, 0, 30, at);
        check("release_latency", 32'(at - e0), 6);
        repeat (5) @(negedge clk);

        // bounce then stable press
        for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0);
            @(negedge clk);
        end
        btn = 1;
        e0 = cyc + 1;
        wait_cond(0, 1, 30, at);
        check("bounce_latency", 32'(at - e0), 6);
        btn = 0;
        repeat (12) @(negedge clk);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                rst = 0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1;
            end
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) begin
                nb = $urandom_range(1, 6);
                for (int k = 0; k < nb; k++) begin
                    btn = ~btn;
                    @(negedge clk);
                end
            end
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        btn = 0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
